fp16_mul_scheduler: RTL and testbench



---
 rtl/fp16_mul_scheduler.sv | 141 ++++++++++++++
 tb/tb_fp16_mul_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_mul_scheduler.sv
// Round-robin front end that shares one pipelined fp16 multiplier among NUM_REQ
// requesters, tagging each operation so its product returns with the owner's ID.
module fp16_mul_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 7,
  parameter int CNT_W   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [15:0]            mul_a,
  output logic [15:0]            mul_b,
  input  logic [15:0]            mul_out,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [15:0]            rsp_data,
  input  logic                   drain_req,
  output logic                   drain_ack,
  output logic                   busy
);

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   last_reg;
  logic [MUL_LAT-1:0] tag_v_reg;
  logic [ID_W-1:0]   tag_id_reg [MUL_LAT];
  logic [CNT_W-1:0]  inflight_reg;

  logic [15:0]       op_a [NUM_REQ];
  logic [15:0]       op_b [NUM_REQ];
  logic              grant_en;
  logic              accept;
  logic [ID_W-1:0]   grant_id;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign op_a[gi]      = req_a[16*gi +: 16];
      assign op_b[gi]      = req_b[16*gi +: 16];
      assign req_ready[gi] = accept && (grant_id == ID_W'(gi));
    end
  endgenerate

  // Gating on drain_req itself (not just the state) blocks grants in the very cycle it rises.
  assign grant_en = (state_reg == RUN) && !drain_req && !rst;

  always_comb begin
    int idx;
    accept   = 1'b0;
    grant_id = '0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_reg) + k) % NUM_REQ;
      if (grant_en && !accept && req_valid[idx]) begin
        accept   = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
  end

  assign mul_a = accept ? op_a[grant_id] : 16'h0000;
  assign mul_b = accept ? op_b[grant_id] : 16'h0000;

  // Tag stage 0 captures every cycle; idle cycles insert a bubble with ID 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_reg[0]  <= 1'b0;
      tag_id_reg[0] <= '0;
    end else begin
      tag_v_reg[0]  <= accept;
      tag_id_reg[0] <= grant_id;
    end
  end

  generate
    for (gi = 1; gi < MUL_LAT; gi++) begin : g_tag
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_v_reg[gi]  <= 1'b0;
          tag_id_reg[gi] <= '0;
        end else begin
          tag_v_reg[gi]  <= tag_v_reg[gi-1];
          tag_id_reg[gi] <= tag_id_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rsp_valid = tag_v_reg[MUL_LAT-1];
  assign rsp_id    = tag_id_reg[MUL_LAT-1];
  assign rsp_data  = rsp_valid ? mul_out : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_reg <= '0;
    end else if (accept && !rsp_valid) begin
      inflight_reg <= inflight_reg + CNT_W'(1);
    end else if (!accept && rsp_valid) begin
      inflight_reg <= inflight_reg - CNT_W'(1);
    end
  end

  assign busy = (inflight_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      last_reg  <= ID_W'(NUM_REQ - 1);
    end else begin
      state_reg <= state_next;
      if (accept) begin
        last_reg <= grant_id;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    drain_ack  = 1'b0;
    case (state_reg)
      RUN: begin
        if (drain_req) state_next = DRAIN;
      end
      DRAIN: begin
        if (!drain_req)                state_next = RUN;
        else if (inflight_reg == '0)   state_next = DRAINED;
      end
      DRAINED: begin
        drain_ack = 1'b1;
        if (!drain_req) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_fp16_mul_scheduler.sv
// Scoreboard bench: a predictor derives grants/products from round-robin and IEEE fp16
// rules, a monitor checks each response against the queued expectation.
module tb_fp16_mul_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int MUL_LAT = 7;
  localparam int CNT_W   = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_a, req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [15:0]           mul_a, mul_b, mul_out;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           rsp_data;
  logic                  drain_req, drain_ack, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp16_mul_scheduler #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .drain_req(drain_req), .drain_ack(drain_ack), .busy(busy)
  );

  // Reference fp16 multiply: round-to-nearest-even, canonical NaN 0x7E00.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic   s;
    int     ea, eb, e, sh, enc;
    longint ma, mb, p, q, rem, half;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);  eb = int'(b[14:10]);
    ma = longint'(a[9:0]); mb = longint'(b[9:0]);
    if ((ea == 31 && ma != 0) || (eb == 31 && mb != 0)) return 16'h7E00;
    if (ea == 31 || eb == 31) begin
      if ((ea == 0 && ma == 0) || (eb == 0 && mb == 0)) return 16'h7E00;
      return {s, 15'h7C00};
    end
    if ((ea == 0 && ma == 0) || (eb == 0 && mb == 0)) return {s, 15'h0000};
    if (ea == 0) ea = 1; else ma = ma + 1024;
    if (eb == 0) eb = 1; else mb = mb + 1024;
    p = ma * mb;
    e = ea + eb - 15;
    while (p < (64'sd1 << 20)) begin
      p = p << 1;
      e = e - 1;
    end
    sh = 10;
    if (p >= (64'sd1 << 21)) begin
      sh = 11;
      e  = e + 1;
    end
    if (e < 1) begin
      sh = sh + 1 - e;
      e  = 0;
    end
    if (sh > 40) sh = 40;
    q    = p >>> sh;
    rem  = p - (q << sh);
    half = 64'sd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (e == 0) enc = int'(q);
    else        enc = ((e - 1) << 10) + int'(q);
    if (enc >= 32'h7C00) enc = 32'h7C00;
    return {s, 15'(enc)};
  endfunction

  // Behavioural multiplier: no reset, MUL_LAT register stages.
  logic [15:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= fmul(mul_a, mul_b);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_out = mpipe[MUL_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [ID_W-1:0] id;
    logic [15:0]     data;
    int              due;
  } exp_t;

  exp_t sb[$];
  int   due_q[$];

  int last_m    = NUM_REQ - 1;
  bit run_m     = 1'b1;
  bit drained_m = 1'b0;

  // Predictor: expected grant, operands, busy and drain_ack for the current cycle.
  always @(negedge clk) begin : predictor
    logic [NUM_REQ-1:0] exp_ready;
    logic [15:0]        ea, eb;
    int                 gid, idx, cnt;
    exp_t               e;
    if (rst) begin
      chk("ready_in_reset", 32'(req_ready), 32'd0);
      last_m    = NUM_REQ - 1;
      run_m     = 1'b1;
      drained_m = 1'b0;
      due_q.delete();
    end else begin
      while (due_q.size() > 0 && due_q[0] < cyc) void'(due_q.pop_front());
      cnt = due_q.size();
      chk("busy", 32'(busy), 32'(cnt != 0));
      chk("drain_ack", 32'(drain_ack), 32'(drained_m));
      exp_ready = '0;
      gid = -1;
      if (run_m && !drain_req) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = (last_m + k) % NUM_REQ;
          if (gid < 0 && req_valid[idx]) gid = idx;
        end
      end
      ea = 16'h0000;
      eb = 16'h0000;
      if (gid >= 0) begin
        exp_ready[gid] = 1'b1;
        ea = req_a[16*gid +: 16];
        eb = req_b[16*gid +: 16];
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("mul_a", 32'(mul_a), 32'(ea));
      chk("mul_b", 32'(mul_b), 32'(eb));
      if (gid >= 0) begin
        e.id   = ID_W'(gid);
        e.data = fmul(ea, eb);
        e.due  = cyc + MUL_LAT;
        sb.push_back(e);
        due_q.push_back(cyc + MUL_LAT);
        last_m = gid;
      end
      drained_m = drain_req && (drained_m || (!run_m && cnt == 0));
      run_m     = !drain_req;
    end
  end

  bit post_rst = 1'b0;

  // Monitor: every presented response must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      sb.delete();
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_rsp_id", 32'(rsp_id), 32'd0);
        post_rst = 1'b0;
      end
      if (rsp_valid !== 1'b0) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          $display("rsp cycle=%0d id=%0d data=%h (expect id=%0d data=%h)",
                   cyc, rsp_id, rsp_data, e.id, e.data);
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end else begin
        chk("rsp_data_idle", 32'(rsp_data), 32'd0);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          chk("rsp_valid_due", 32'(rsp_valid), 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    drain_req = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_fp();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 9))
      0: return {r[15], 15'h7C00};
      1: return {r[15], 15'h0000};
      2: return 16'h7C01 | (r & 16'h03FF);
      3: return r & 16'h83FF;
      default: return r;
    endcase
  endfunction

  initial begin
    bit got_ack;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; drain_req = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // single request from requester 2: 2.0 * 3.0
    set_op(2, 16'h4000, 16'h4200);
    req_valid = 4'b0100;
    tick(1);
    req_valid = '0;
    tick(MUL_LAT + 2);

    // all requesters for 8 cycles right after reset: 1.0 * 1.0
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 16'h3C00, 16'h3C00);
    req_valid = '1;
    tick(8);
    req_valid = '0;
    tick(MUL_LAT + 2);

    // fairness between requesters 1 and 3
    for (int i = 0; i < NUM_REQ; i++) set_op(i, rand_fp(), rand_fp());
    req_valid = 4'b1010;
    tick(8);
    req_valid = '0;
    tick(MUL_LAT + 2);

    // drain with 3 in flight and requests still pending
    req_valid = '1;
    tick(3);
    drain_req = 1'b1;
    got_ack = 1'b0;
    for (int i = 0; i < MUL_LAT + 3 && !got_ack; i++) begin
      tick(1);
      got_ack = drain_ack;
    end
    chk("drain_ack_within_bound", 32'(got_ack), 32'd1);
    tick(2);
    drain_req = 1'b0;
    tick(3);
    req_valid = '0;
    tick(MUL_LAT + 2);

    // reset pulse with 4 operations in flight
    req_valid = '1;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req_valid = '0;
    tick(MUL_LAT + 2);
    req_valid = '1;
    tick(1);
    req_valid = '0;
    tick(MUL_LAT + 2);

    // inf * 0 from requester 0 alongside requester 1
    set_op(0, 16'h7C00, 16'h0000);
    set_op(1, 16'h3E00, 16'h4000);
    req_valid = 4'b0011;
    tick(2);
    req_valid = '0;
    tick(MUL_LAT + 2);

    // randomized traffic with occasional drain toggling
    repeat (400) begin
      req_valid = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) set_op(i, rand_fp(), rand_fp());
      if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
      tick(1);
    end
    req_valid = '0;
    drain_req = 1'b0;
    tick(MUL_LAT + 3);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
